// File: rtl/fisc_uart_pkg.sv
// Shared definitions for the FISC UART: FSM state encodings, bit-count width, default parameters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fisc_uart_pkg;

    // Common encoding for the TX and RX serial state machines.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Counts the 8 data bits of a frame.
    localparam int BIT_CNT_W = 3;

    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_RX_DEPTH     = 16;

endpackage

// File: rtl/fisc_uart_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible on head_dat whenever empty is low.
// Latency: a push is visible at the head after the push edge; a pop advances the head after its edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
//
// Ports: clk, rst_n (async active-low), push/push_dat, pop, full, empty, head_dat.
module fisc_uart_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra pointer bit tells a full FIFO from an empty one.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/fisc_uart.sv
// 8N1 UART for the FISC CPU data-bus slot: one-deep TX holding register + shifter, RX into a show-ahead FIFO.
// Latency: TX start bit one cycle after the write strobe; RX byte visible right after the stop-sample edge.
// Backpressure: writes while tx_ready=0 are dropped; RX bytes arriving with the FIFO full are dropped and flag rx_err.
//
// Ports: i_clk, reset (async active-low), databus/tx_wr_n (CPU write), rx_rd_n (CPU pop),
//        UARTval/rx_avail/tx_ready/rx_err (CPU-visible status), rxd/txd (serial lines).
module fisc_uart
    import fisc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int RX_DEPTH     = DEF_RX_DEPTH
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic [7:0] databus,
    input  logic       tx_wr_n,
    input  logic       rx_rd_n,
    output logic [7:0] UARTval,
    output logic       rx_avail,
    output logic       tx_ready,
    output logic       rx_err,
    input  logic       rxd,
    output logic       txd
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = '1;

    // ---------------- transmit ----------------
    uart_state_t          tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [BIT_CNT_W-1:0] tx_bit;
    logic [7:0]           tx_shift;
    logic [7:0]           hold_dat;
    logic                 hold_full;

    assign tx_ready = ~hold_full;

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            tx_state  <= ST_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            hold_dat  <= '0;
            hold_full <= 1'b0;
            txd       <= 1'b1;
        end else begin
            // The strobe only lands when the holding register is empty, and the FSM
            // only drains it when full, so these two never fight over hold_full.
            if (!tx_wr_n && !hold_full) begin
                hold_dat  <= databus;
                hold_full <= 1'b1;
            end
            case (tx_state)
                ST_IDLE: begin
                    txd <= 1'b1;
                    if (hold_full) begin
                        tx_shift  <= hold_dat;
                        hold_full <= 1'b0;
                        tx_cnt    <= '0;
                        txd       <= 1'b0;
                        tx_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd      <= tx_shift[0];
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == BIT_LAST) begin
                            txd      <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            txd      <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (tx_cnt == CNT_LAST) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit: no idle gap between frames.
                        if (hold_full) begin
                            tx_shift  <= hold_dat;
                            hold_full <= 1'b0;
                            txd       <= 1'b0;
                            tx_state  <= ST_START;
                        end else begin
                            txd      <= 1'b1;
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- receive ----------------
    uart_state_t          rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [BIT_CNT_W-1:0] rx_bit;
    logic [7:0]           rx_shift;
    logic [1:0]           rx_sync;
    logic                 rx_s;
    // Set once the line has been seen high in IDLE; stops a held-low line
    // (e.g. after a framing error) from retriggering a start bit.
    logic                 rx_armed;

    logic       pop_req;
    logic       stop_sample;
    logic       fifo_push;
    logic       fifo_full;
    logic       fifo_empty;
    logic       err_set;
    logic [7:0] fifo_head;

    assign rx_s        = rx_sync[1];
    assign pop_req     = ~rx_rd_n;
    assign stop_sample = (rx_state == ST_STOP) && (rx_cnt == CNT_LAST);
    assign fifo_push   = stop_sample && rx_s && (!fifo_full || pop_req);
    assign err_set     = stop_sample && (!rx_s || (fifo_full && !pop_req));

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            rx_sync  <= 2'b11;
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_armed <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rxd};

            if (err_set)      rx_err <= 1'b1;
            else if (pop_req) rx_err <= 1'b0;

            case (rx_state)
                ST_IDLE: begin
                    if (rx_s) begin
                        rx_armed <= 1'b1;
                    end else if (rx_armed) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    // Mid start bit: a high line here means it was only a glitch.
                    if (rx_cnt == CNT_HALF) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_bit == BIT_LAST) rx_state <= ST_STOP;
                        else                    rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt == CNT_LAST) begin
                        rx_cnt   <= '0;
                        rx_armed <= 1'b0;
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    fisc_uart_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk      (i_clk),
        .rst_n    (reset),
        .push     (fifo_push),
        .push_dat (rx_shift),
        .pop      (pop_req),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (fifo_head)
    );

    assign rx_avail = ~fifo_empty;
    assign UARTval  = fifo_empty ? 8'h00 : fifo_head;

endmodule
